// File: rtl/epu_dma_master_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// epu_dma_master_pkg : shared FSM state type, AXI constants and burst helper.
// Rev 1.0
// ----------------------------------------------------------------------------
package epu_dma_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_DONE = 3'd6
  } epu_dma_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [4:0] burst_beats(input logic [15:0] remaining,
                                             input logic [4:0]  burst_max);
    if (remaining > {11'd0, burst_max}) burst_beats = burst_max;
    else                                burst_beats = remaining[4:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/epu_dma_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inf_Master : AXI master bundle; M2AXIout = driven by the DMA, M2AXIin = seen.
// Rev 1.0
// ----------------------------------------------------------------------------
interface inf_Master;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport M2AXIout (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready
  );

  modport M2AXIin (
    input arready, rid, rdata, rresp, rlast, rvalid,
    input awready, wready, bid, bresp, bvalid
  );

endinterface
`default_nettype wire

// File: rtl/epu_dma_master_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// epu_dma_buf : burst staging buffer, one write port, combinational read.
// Rev 1.0
// ----------------------------------------------------------------------------
module epu_dma_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  wire logic          clk,
  input  wire logic          we_i,
  input  wire logic [AW-1:0] waddr_i,
  input  wire logic [31:0]   wdata_i,
  input  wire logic [AW-1:0] raddr_i,
  output logic      [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/epu_dma_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// epu_dma_master : memory-to-memory copy engine, read burst then write burst.
// Rev 1.0
// ----------------------------------------------------------------------------
module epu_dma_master
  import epu_dma_master_pkg::*;
#(
  parameter logic [3:0]  AXI_ID    = 4'h1,
  parameter int unsigned BURST_MAX = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start_i,
  input  wire logic [31:0] src_addr_i,
  input  wire logic [31:0] dst_addr_i,
  input  wire logic [15:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  inf_Master.M2AXIout      m2axi_o,
  inf_Master.M2AXIin       m2axi_i
);

  localparam logic [4:0] BEATS_MAX = 5'(BURST_MAX);

  epu_dma_state_t state_q;
  logic [31:0]    src_q;
  logic [31:0]    dst_q;
  logic [15:0]    rem_q;
  logic [4:0]     beats_q;
  logic [3:0]     rcnt_q;
  logic [3:0]     wcnt_q;
  logic           rerr_q;
  logic           err_q;
  logic           arvalid_q;
  logic           awvalid_q;
  logic           wvalid_q;
  logic           rready_q;
  logic           bready_q;

  logic [15:0]    rem_d;
  logic [31:0]    bytes_d;
  logic [3:0]     last_idx_d;
  logic           r_bad_d;
  logic           buf_we_d;
  logic [31:0]    buf_rdata_d;
  logic           unused_ids;

  assign rem_d      = rem_q - {11'd0, beats_q};
  assign bytes_d    = {25'd0, beats_q, 2'b00};
  assign last_idx_d = 4'(beats_q - 5'd1);
  assign r_bad_d    = (m2axi_i.rresp != AXI_RESP_OKAY);
  assign buf_we_d   = rready_q & m2axi_i.rvalid;
  assign unused_ids = ^{m2axi_i.rid, m2axi_i.bid};

  epu_dma_buf #(
    .DEPTH (BURST_MAX),
    .AW    (4)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we_d),
    .waddr_i (rcnt_q),
    .wdata_i (m2axi_i.rdata),
    .raddr_i (wcnt_q),
    .rdata_o (buf_rdata_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      beats_q   <= '0;
      rcnt_q    <= '0;
      wcnt_q    <= '0;
      rerr_q    <= 1'b0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            src_q   <= src_addr_i;
            dst_q   <= dst_addr_i;
            rem_q   <= len_i;
            beats_q <= burst_beats(len_i, BEATS_MAX);
            err_q   <= 1'b0;
            if (len_i == 16'd0) begin
              state_q <= ST_DONE;
            end else begin
              state_q   <= ST_AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (m2axi_i.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            rcnt_q    <= '0;
            rerr_q    <= 1'b0;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (m2axi_i.rvalid) begin
            rcnt_q <= rcnt_q + 4'd1;
            if (r_bad_d) begin
              rerr_q <= 1'b1;
              err_q  <= 1'b1;
            end
            // A failed read still drains the burst but never reaches the write side.
            if (m2axi_i.rlast) begin
              rready_q <= 1'b0;
              if (rerr_q || r_bad_d) begin
                state_q <= ST_DONE;
              end else begin
                state_q   <= ST_AW;
                awvalid_q <= 1'b1;
              end
            end
          end
        end
        ST_AW: begin
          if (m2axi_i.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wcnt_q    <= '0;
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (m2axi_i.wready) begin
            if (wcnt_q == last_idx_d) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end else begin
              wcnt_q <= wcnt_q + 4'd1;
            end
          end
        end
        ST_B: begin
          if (m2axi_i.bvalid) begin
            bready_q <= 1'b0;
            if (m2axi_i.bresp != AXI_RESP_OKAY) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              src_q <= src_q + bytes_d;
              dst_q <= dst_q + bytes_d;
              rem_q <= rem_d;
              if (rem_d != 16'd0) begin
                beats_q   <= burst_beats(rem_d, BEATS_MAX);
                arvalid_q <= 1'b1;
                state_q   <= ST_AR;
              end else begin
                state_q <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign err_o  = err_q;

  assign m2axi_o.arid    = AXI_ID;
  assign m2axi_o.araddr  = src_q;
  assign m2axi_o.arlen   = {4'd0, last_idx_d};
  assign m2axi_o.arsize  = AXI_SIZE_4B;
  assign m2axi_o.arburst = AXI_BURST_INCR;
  assign m2axi_o.arvalid = arvalid_q;
  assign m2axi_o.rready  = rready_q;

  assign m2axi_o.awid    = AXI_ID;
  assign m2axi_o.awaddr  = dst_q;
  assign m2axi_o.awlen   = {4'd0, last_idx_d};
  assign m2axi_o.awsize  = AXI_SIZE_4B;
  assign m2axi_o.awburst = AXI_BURST_INCR;
  assign m2axi_o.awvalid = awvalid_q;

  assign m2axi_o.wdata   = buf_rdata_d;
  assign m2axi_o.wstrb   = 4'hF;
  assign m2axi_o.wlast   = (wcnt_q == last_idx_d);
  assign m2axi_o.wvalid  = wvalid_q;
  assign m2axi_o.bready  = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_epu_dma_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_epu_dma_master : AXI slave model plus burst-list reference for the DMA.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_epu_dma_master;

  localparam int BM = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o;

  inf_Master axi ();

  epu_dma_master #(.AXI_ID(4'h1), .BURST_MAX(BM)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .m2axi_o    (axi),
    .m2axi_i    (axi)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int beats; } burst_t;

  int total = 0;
  int bad   = 0;

  burst_t      rq[$];
  burst_t      awq[$];
  burst_t      ar_log[$];
  burst_t      aw_log[$];
  logic [31:0] wmem [logic [31:0]];
  int          rbeat, wbeat, b_pend, n_rbeats, err_beat, done_cnt;
  bit          stall, r_hs, b_hs, aw_seen;
  bit          p_ar_wait, p_aw_wait, p_w_wait;
  logic [44:0] p_ar, p_aw;
  logic [36:0] p_w;
  logic [31:0] seed = 32'h1234_5678;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  task automatic slave_reset();
    rq.delete(); awq.delete();
    rbeat = 0; wbeat = 0; b_pend = 0; r_hs = 0; b_hs = 0;
    p_ar_wait = 0; p_aw_wait = 0; p_w_wait = 0;
    axi.arready = 0; axi.awready = 0; axi.wready = 0;
    axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0; axi.rid = 4'h1;
    axi.bvalid = 0; axi.bresp = '0; axi.bid = 4'h1;
  endtask

  // One clock: retire last handshakes, drive new slave inputs, then record what
  // the coming rising edge will accept.
  task automatic tick();
    burst_t     b;
    logic [31:0] a;
    @(negedge clk);
    if (r_hs) axi.rvalid = 0;
    if (b_hs) axi.bvalid = 0;
    r_hs = 0; b_hs = 0;
    axi.arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    axi.awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    axi.wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!axi.rvalid && rq.size() > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
      axi.rvalid = 1;
      axi.rdata  = src_word(rq[0].addr + 32'(4 * rbeat));
      axi.rlast  = (rbeat == rq[0].beats - 1);
      axi.rresp  = (rbeat == err_beat) ? 2'b10 : 2'b00;
    end
    if (!axi.bvalid && b_pend > 0 && (!stall || $urandom_range(0, 1) != 0)) begin
      axi.bvalid = 1;
      axi.bresp  = 2'b00;
    end

    check_eq("ar_aw_excl", axi.arvalid & axi.awvalid, 0);
    if (p_ar_wait)
      check_eq("ar_hold", {axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst}, {1'b1, p_ar});
    if (p_aw_wait)
      check_eq("aw_hold", {axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst}, {1'b1, p_aw});
    if (p_w_wait)
      check_eq("w_hold", {axi.wvalid, axi.wdata, axi.wlast, axi.wstrb}, {1'b1, p_w});

    if (axi.arvalid && axi.arready) begin
      b.addr = axi.araddr; b.beats = int'(axi.arlen) + 1;
      rq.push_back(b); ar_log.push_back(b);
      check_eq("ar_attr", {axi.arsize, axi.arburst, axi.arid}, {3'b010, 2'b01, 4'h1});
    end
    if (axi.rvalid && axi.rready) begin
      r_hs = 1; n_rbeats++; rbeat++;
      if (axi.rlast) begin
        rq.delete(0);
        rbeat = 0;
      end
    end
    if (axi.awvalid) aw_seen = 1;
    if (axi.awvalid && axi.awready) begin
      b.addr = axi.awaddr; b.beats = int'(axi.awlen) + 1;
      awq.push_back(b); aw_log.push_back(b);
      check_eq("aw_attr", {axi.awsize, axi.awburst, axi.awid}, {3'b010, 2'b01, 4'h1});
    end
    if (axi.wvalid && axi.wready) begin
      check_eq("w_has_aw", awq.size(), 1);
      if (awq.size() > 0) begin
        a = awq[0].addr + 32'(4 * wbeat);
        wmem[a] = axi.wdata;
        check_eq("wlast", axi.wlast, wbeat == awq[0].beats - 1);
        check_eq("wstrb", axi.wstrb, 4'hF);
        wbeat++;
        if (wbeat == awq[0].beats) begin
          awq.delete(0);
          wbeat = 0;
          b_pend++;
        end
      end
    end
    if (axi.bvalid && axi.bready) begin
      b_hs = 1;
      b_pend--;
    end

    p_ar_wait = axi.arvalid && !axi.arready;
    p_ar      = {axi.araddr, axi.arlen, axi.arsize, axi.arburst};
    p_aw_wait = axi.awvalid && !axi.awready;
    p_aw      = {axi.awaddr, axi.awlen, axi.awsize, axi.awburst};
    p_w_wait  = axi.wvalid && !axi.wready;
    p_w       = {axi.wdata, axi.wlast, axi.wstrb};
    if (done_o) done_cnt++;
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] len, input int err_at, input bit poke);
    burst_t      exp_b[$];
    burst_t      b;
    int          off, cyc;
    logic [31:0] a;
    ar_log.delete(); aw_log.delete(); wmem.delete();
    n_rbeats = 0; done_cnt = 0; aw_seen = 0; err_beat = err_at;
    src_addr_i = src; dst_addr_i = dst; len_i = len; start_i = 1;
    tick();
    start_i = 0;
    check_eq({tag, ":busy"}, busy_o, 1);
    check_eq({tag, ":err_clr"}, err_o, 0);
    if (len == 16'd0) check_eq({tag, ":done_lat"}, done_o, 1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      if (poke && cyc == 2) begin
        start_i = 1; src_addr_i = 32'hDEAD_0000; dst_addr_i = 32'hBEEF_0000; len_i = 16'd3;
      end
      if (poke && cyc == 4) start_i = 0;
      tick();
      cyc++;
    end
    start_i = 0;
    check_eq({tag, ":done_seen"}, done_cnt, 1);
    tick();
    check_eq({tag, ":done_pulse"}, {done_o, busy_o}, 2'b00);
    check_eq({tag, ":err"}, err_o, err_at >= 0);

    off = 0;
    while (off < int'(len)) begin
      b.addr  = src + 32'(4 * off);
      b.beats = (int'(len) - off > BM) ? BM : int'(len) - off;
      exp_b.push_back(b);
      off += b.beats;
    end
    if (err_at < 0) begin
      check_eq({tag, ":n_ar"}, ar_log.size(), exp_b.size());
      check_eq({tag, ":n_aw"}, aw_log.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < ar_log.size() && i < aw_log.size(); i++) begin
        check_eq({tag, ":ar"}, {ar_log[i].addr, 32'(ar_log[i].beats)},
                 {exp_b[i].addr, 32'(exp_b[i].beats)});
        check_eq({tag, ":aw"}, {aw_log[i].addr, 32'(aw_log[i].beats)},
                 {dst + (exp_b[i].addr - src), 32'(exp_b[i].beats)});
      end
      for (int i = 0; i < int'(len); i++) begin
        a = dst + 32'(4 * i);
        check_eq({tag, ":data"}, wmem.exists(a) ? wmem[a] : ~src_word(src + 32'(4 * i)),
                 src_word(src + 32'(4 * i)));
      end
      check_eq({tag, ":n_words"}, wmem.num(), len);
    end else begin
      check_eq({tag, ":n_ar"}, ar_log.size(), 1);
      check_eq({tag, ":r_drain"}, n_rbeats, exp_b[0].beats);
      check_eq({tag, ":no_aw"}, aw_seen, 0);
      check_eq({tag, ":n_words"}, wmem.num(), 0);
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] s, d;
    slave_reset();
    stall = 0; err_beat = -1; done_cnt = 0;
    tick(); tick();
    check_eq("reset_outs", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
                            busy_o, done_o, err_o}, 8'h00);
    rst = 1;
    tick();
    check_eq("idle_after_rst", {busy_o, axi.arvalid}, 2'b00);

    run_xfer("len5", 32'h0000_1000, 32'h5000_0000, 16'd5, -1, 1);
    run_xfer("len37", 32'h0000_2000, 32'h5000_0000, 16'd37, -1, 0);

    stall = 1; seed = $urandom;
    run_xfer("stall20", $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 16'd20, -1, 0);
    stall = 0;

    run_xfer("rerr", 32'h0000_4000, 32'h5000_1000, 16'd8, 2, 0);
    tick(); tick(); tick();
    check_eq("err_sticky", err_o, 1);

    run_xfer("len0", 32'h0000_5000, 32'h5000_2000, 16'd0, -1, 0);

    // Reset while the fourth write beat is on the bus
    wmem.delete(); err_beat = -1;
    src_addr_i = 32'h0000_3000; dst_addr_i = 32'h6000_0000; len_i = 16'd8; start_i = 1;
    tick();
    start_i = 0;
    cyc = 0;
    while (wbeat != 3 && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq("rst:reach_w3", wbeat, 3);
    @(posedge clk);
    #2 rst = 0;
    #1;
    check_eq("rst:outs", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
                          busy_o, done_o, err_o}, 8'h00);
    slave_reset();
    tick(); tick();
    check_eq("rst:held", {busy_o, axi.arvalid, axi.wvalid}, 3'b000);
    rst = 1;
    run_xfer("after_rst", 32'h0000_3000, 32'h6000_0000, 16'd12, -1, 0);

    for (int k = 0; k < 4; k++) begin
      stall = 1'($urandom_range(0, 1));
      seed  = $urandom;
      s = (k == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      d = $urandom & 32'hFFFF_FFFC;
      run_xfer($sformatf("rnd%0d", k), s, d, 16'($urandom_range(1, 40)), -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/epu_dma_master.md
EPU_DMA_MASTER -- requirements
Module: epu_dma_master

Interface
REQ-001 The block SHALL have parameter AXI_ID, default 4'h1: ID driven on arid/awid; bid/rid are not checked.
REQ-002 The block SHALL have parameter BURST_MAX, default 16: maximum beats per burst, with 1 <= BURST_MAX <= 16.
REQ-003 The block SHALL have port clk  in  1  as the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  in  1  as the reset: asynchronous, active-low (asserted at 0).
REQ-005 The block SHALL have port start_i  in  1  as the transfer request; it is sampled in IDLE only.
REQ-006 The block SHALL have port src_addr_i  in  32  as the source byte address, word aligned, latched on start.
REQ-007 The block SHALL have port dst_addr_i  in  32  as the destination byte address, word aligned, latched on start.
REQ-008 The block SHALL have port len_i  in  16  as the transfer length in 32-bit words, latched on start.
REQ-009 The block SHALL have port busy_o  out  1  meaning a transfer is in progress.
REQ-010 The block SHALL have port done_o  out  1  as a one-cycle completion pulse.
REQ-011 The block SHALL have port err_o  out  1  as a sticky error flag, cleared on the next accepted start.
REQ-012 The block SHALL have port m2axi_o  out  inf_Master.M2AXIout  carrying AR, AW and W channel outputs plus rready and bready.
REQ-013 The block SHALL have port m2axi_i  in  inf_Master.M2AXIin  carrying arready, awready, wready, R channel and B channel.

Function
REQ-014 The FSM SHALL have states IDLE, AR, R, AW, W, B, DONE.
REQ-015 In IDLE, start_i=1 SHALL latch the inputs, clear err_o and go to AR; if len_i=0 it SHALL go straight to DONE.
REQ-016 start_i SHALL be ignored outside IDLE.
REQ-017 Beats per burst SHALL be min(remaining, BURST_MAX), computed on entry to AR; arlen/awlen = beats-1.
REQ-018 In AR, arvalid=1 with araddr=cur_src, arsize=3'b010 and arburst=INCR; all SHALL stay stable until arready, then go to R.
REQ-019 In R, rready=1; each rdata beat SHALL be written to a BURST_MAX x 32 buffer at index rcnt; on rlast&rvalid go to AW, or to DONE if any beat of the burst had rresp!=OKAY.
REQ-020 In AW, awvalid=1 with awaddr=cur_dst, awsize=3'b010 and awburst=INCR, held stable until awready, then go to W.
REQ-021 In W, wvalid=1, wdata=buffer[wcnt], wstrb=4'hF, and wlast=1 iff wcnt==beats-1; wcnt SHALL advance only on wvalid&wready.
REQ-022 After the wlast handshake the FSM SHALL go to B with bready=1.
REQ-023 On bvalid with bresp=OKAY: cur_src += 4*beats, cur_dst += 4*beats, remaining -= beats; then go to AR if remaining>0, else DONE.
REQ-024 bresp!=OKAY SHALL set err_o and go to DONE.
REQ-025 rresp!=OKAY SHALL set err_o; the R burst SHALL still drain to rlast and no write SHALL be issued for that burst.
REQ-026 DONE SHALL last one cycle with done_o=1, then go to IDLE.
REQ-027 busy_o SHALL be 1 in every state except IDLE.
REQ-028 arvalid and awvalid SHALL never be 1 in the same cycle.
REQ-029 No valid SHALL deassert before its ready.
REQ-030 Address arithmetic SHALL be 32-bit wrap-around and is not checked against 4 KB boundaries.
REQ-031 rcnt and wcnt SHALL be 4-bit and reset to 0 on entry to R and W respectively.

Reset
REQ-032 While rst=0: state=IDLE; all valid/ready outputs 0; busy_o, done_o, err_o = 0; counters, addresses and remaining = 0.
REQ-033 Reset mid-burst SHALL drop all valids immediately; the buffer contents are don't-care.

Structure
REQ-034 The state enum epu_dma_state_t and the AXI_BURST_INCR / AXI_SIZE_4B constants SHALL live in the shared EPU package.
REQ-035 The burst buffer SHALL be one sub-module, epu_dma_buf: 1 write port, 1 combinational read port, no reset on storage.

Verification
REQ-036 Bench SHALL cover: len=5, src=0x0000_1000, dst=0x5000_0000, slave always ready -> one burst, arlen=awlen=4, 5 words copied, done_o pulse.
REQ-037 Bench SHALL cover: len=37, BURST_MAX=16 -> bursts of 16/16/5 beats; awaddr sequence 0x5000_0000, 0x5000_0040, 0x5000_0080.
REQ-038 Bench SHALL cover: random arready/wready/rvalid stalls on len=20 -> valids and payload held stable, data matches source.
REQ-039 Bench SHALL cover: rresp=SLVERR on beat 2 of 8 -> all 8 R beats drained, no awvalid, err_o=1, done_o pulse.
REQ-040 Bench SHALL cover: len=0 -> done_o one cycle after start, no AXI activity; a start asserted while busy has no effect.
REQ-041 Bench SHALL cover: rst=0 asserted during W beat 3 -> outputs at reset values in the same cycle; a new start after release completes normally.
